// File: rtl/instruction_fetcher_if.sv
// Fetch-stage bus bundling predictor, instruction-queue, memory-controller and ROB-flush signals.
// Latency: none, pure wiring between the fetcher and its neighbours.
// Backpressure: iq_full, stop_fetching and rdy_in travel towards the fetcher on this bus.
interface instruction_fetcher_if;
    logic        rdy_in;
    logic [31:0] pc_in;
    logic        pc_predict;
    logic        stop_fetching;
    logic        roll_back;
    logic        iq_full;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        fetch_new_instruction;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_predict;

    // Fetcher side.
    modport master (
        input  rdy_in, pc_in, pc_predict, stop_fetching, roll_back, iq_full,
        input  mem_done, mem_data,
        output mem_req, mem_addr,
        output fetch_new_instruction, inst_out, inst_pc, inst_predict
    );

    // Environment side: predictor, instruction queue, memory controller, ROB.
    modport slave (
        output rdy_in, pc_in, pc_predict, stop_fetching, roll_back, iq_full,
        output mem_done, mem_data,
        input  mem_req, mem_addr,
        input  fetch_new_instruction, inst_out, inst_pc, inst_predict
    );
endinterface

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: looks pc_in up in a direct-mapped one-word-per-line I-cache (macro ICACHE_EN), else fetches from memory.
// Latency: hit issues 1 edge after IDLE (1 instr / 2 cycles); miss issues 1 edge after mem_done.
// Backpressure: stop_fetching/iq_full/roll_back hold IDLE; iq_full at mem_done parks the word until the queue frees; rdy_in low freezes everything.
module instruction_fetcher #(
    parameter int ICACHE_LINES = 64
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    instruction_fetcher_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MISS = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        discard_q, discard_d;
    logic        pending_q, pending_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        req_predict_q, req_predict_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        fetch_q, fetch_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_predict_q, inst_predict_d;

    logic        hit;
    logic [31:0] hit_data;
    logic        fill_en;

`ifdef ICACHE_EN
    localparam int IDX  = $clog2(ICACHE_LINES);
    localparam int TAGW = 30 - IDX;

    logic [ICACHE_LINES-1:0] valid_q;
    logic [TAGW-1:0]         tag_q  [ICACHE_LINES];
    logic [31:0]             data_q [ICACHE_LINES];
    logic [IDX-1:0]          lk_idx;
    logic [IDX-1:0]          fill_idx;

    // Lookup uses the live predicted PC; the fill uses the PC latched at request time.
    assign lk_idx   = bus.pc_in[IDX+1:2];
    assign fill_idx = req_pc_q[IDX+1:2];
    assign hit      = valid_q[lk_idx] && (tag_q[lk_idx] == bus.pc_in[31:IDX+2]);
    assign hit_data = data_q[lk_idx];

    // Valid bits: wiped by reset (including mid-miss), set by each completed fill.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (bus.rdy_in && fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag/data storage: unreset, the valid bits qualify every entry.
    always_ff @(posedge clk_in) begin
        if (!rst_in && bus.rdy_in && fill_en) begin
            tag_q[fill_idx]  <= req_pc_q[31:IDX+2];
            data_q[fill_idx] <= bus.mem_data;
        end
    end
`else
    // No cache: every fetch goes to memory and the line-count parameter has no effect.
    logic [31:0] unused_lines;
    logic        unused_fill;
    assign unused_lines = ICACHE_LINES;
    assign unused_fill  = fill_en;
    assign hit          = 1'b0;
    assign hit_data     = '0;
`endif

    // Next-state logic for the IDLE/MISS/COOL fetch sequence.
    always_comb begin
        state_d        = state_q;
        discard_d      = discard_q;
        pending_d      = pending_q;
        pend_data_d    = pend_data_q;
        req_pc_d       = req_pc_q;
        req_predict_d  = req_predict_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        fetch_d        = 1'b0;
        inst_out_d     = inst_out_q;
        inst_pc_d      = inst_pc_q;
        inst_predict_d = inst_predict_q;
        fill_en        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!(bus.stop_fetching || bus.iq_full || bus.roll_back)) begin
                    if (hit) begin
                        fetch_d        = 1'b1;
                        inst_out_d     = hit_data;
                        inst_pc_d      = bus.pc_in;
                        inst_predict_d = bus.pc_predict;
                        state_d        = S_COOL;
                    end else begin
                        mem_req_d     = 1'b1;
                        mem_addr_d    = {bus.pc_in[31:2], 2'b00};
                        req_pc_d      = bus.pc_in;
                        req_predict_d = bus.pc_predict;
                        state_d       = S_MISS;
                    end
                end
            end
            S_MISS: begin
                if (pending_q) begin
                    // Word already fetched, waiting for queue space; a flush makes it stale.
                    if (bus.roll_back) begin
                        pending_d = 1'b0;
                        state_d   = S_IDLE;
                    end else if (!bus.iq_full) begin
                        pending_d      = 1'b0;
                        fetch_d        = 1'b1;
                        inst_out_d     = pend_data_q;
                        inst_pc_d      = req_pc_q;
                        inst_predict_d = req_predict_q;
                        state_d        = S_COOL;
                    end
                end else if (bus.mem_done) begin
                    mem_req_d = 1'b0;
                    fill_en   = 1'b1;
                    if (discard_q || bus.roll_back) begin
                        discard_d = 1'b0;
                        state_d   = S_IDLE;
                    end else if (!bus.iq_full) begin
                        fetch_d        = 1'b1;
                        inst_out_d     = bus.mem_data;
                        inst_pc_d      = req_pc_q;
                        inst_predict_d = req_predict_q;
                        state_d        = S_COOL;
                    end else begin
                        pending_d   = 1'b1;
                        pend_data_d = bus.mem_data;
                    end
                end else if (bus.roll_back) begin
                    // The memory request cannot be cancelled; remember to drop its result.
                    discard_d = 1'b1;
                end
            end
            S_COOL: begin
                // One idle edge lets the predictor advance pc_in after the pulse.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers: reset wins, rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= S_IDLE;
            discard_q      <= 1'b0;
            pending_q      <= 1'b0;
            pend_data_q    <= '0;
            req_pc_q       <= '0;
            req_predict_q  <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            fetch_q        <= 1'b0;
            inst_out_q     <= '0;
            inst_pc_q      <= '0;
            inst_predict_q <= 1'b0;
        end else if (bus.rdy_in) begin
            state_q        <= state_d;
            discard_q      <= discard_d;
            pending_q      <= pending_d;
            pend_data_q    <= pend_data_d;
            req_pc_q       <= req_pc_d;
            req_predict_q  <= req_predict_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            fetch_q        <= fetch_d;
            inst_out_q     <= inst_out_d;
            inst_pc_q      <= inst_pc_d;
            inst_predict_q <= inst_predict_d;
        end
    end

    assign bus.mem_req               = mem_req_q;
    assign bus.mem_addr              = mem_addr_q;
    assign bus.fetch_new_instruction = fetch_q;
    assign bus.inst_out              = inst_out_q;
    assign bus.inst_pc               = inst_pc_q;
    assign bus.inst_predict          = inst_predict_q;
endmodule
